// File: rtl/e203_nice_csr_resp_pkg.sv
// NICE CSR responder shared definitions.
// CSR indices, field bit positions, FSM states.
package e203_nice_csr_resp_pkg;

    localparam logic [11:0] CSR_NCTRL = 12'hE00;
    localparam logic [11:0] CSR_NSTAT = 12'hE01;
    localparam logic [11:0] CSR_NARG0 = 12'hE02;
    localparam logic [11:0] CSR_NARG1 = 12'hE03;
    localparam logic [11:0] CSR_NRES  = 12'hE04;
    localparam logic [11:0] CSR_NCYC  = 12'hE05;

    localparam int NCTRL_START  = 0;
    localparam int NCTRL_IRQ_EN = 1;
    localparam int NSTAT_BUSY   = 0;
    localparam int NSTAT_DONE   = 1;
    localparam int NSTAT_ERR    = 2;

    localparam logic [4:0] MUL_LAST = 5'd31;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } nice_state_e;

endpackage

// File: rtl/e203_nice_seqmul.sv
// Shift-add sequential multiplier, 32 steps, low 32 bits.
// start loads a/b; done pulses in the last step with result valid.
module e203_nice_seqmul
    import e203_nice_csr_resp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] result
);

    logic        active;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [4:0]  cnt;
    logic [31:0] acc_next;

    assign acc_next = acc + (mplier[0] ? mcand : 32'd0);
    assign done     = active && (cnt == MUL_LAST);
    // Result includes the final step's partial product.
    assign result   = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
        end else if (active) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
            if (cnt == MUL_LAST) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/e203_nice_csr_resp.sv
// NICE CSR bank with a 32-cycle multiply engine.
// Ports: CSR valid/ready/addr/wr/wdata/rdata, nice_irq, nice_busy.
module e203_nice_csr_resp
    import e203_nice_csr_resp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nice_csr_valid,
    output logic        nice_csr_ready,
    input  logic [31:0] nice_csr_addr,
    input  logic        nice_csr_wr,
    input  logic [31:0] nice_csr_wdata,
    output logic [31:0] nice_csr_rdata,
    output logic        nice_irq,
    output logic        nice_busy
);

    nice_state_e state, state_next;

    logic        irq_en;
    logic        done_f;
    logic        err_f;
    logic [31:0] narg0;
    logic [31:0] narg1;
    logic [31:0] nres;
    logic [31:0] ncyc;

    logic [11:0] idx;
    logic        mapped;
    logic        accept;
    logic        wr_acc;
    logic        start;
    logic        mul_done;
    logic [31:0] mul_res;

    // Upper index bits are deliberately not decoded.
    wire unused_addr = ^nice_csr_addr[31:12];

    assign idx    = nice_csr_addr[11:0];
    assign mapped = (idx >= CSR_NCTRL) && (idx <= CSR_NCYC);

    // In BUSY only status and cycle counter may be accessed.
    assign nice_csr_ready = (state == ST_IDLE)
                          || (idx == CSR_NSTAT)
                          || (idx == CSR_NCYC);

    assign accept = nice_csr_valid && nice_csr_ready;
    assign wr_acc = accept && nice_csr_wr;
    assign start  = wr_acc && (idx == CSR_NCTRL)
                  && nice_csr_wdata[NCTRL_START]
                  && (state == ST_IDLE);

    assign nice_busy = (state == ST_BUSY);
    assign nice_irq  = done_f && irq_en;

    always_comb begin
        nice_csr_rdata = '0;
        case (idx)
            CSR_NCTRL: nice_csr_rdata[NCTRL_IRQ_EN] = irq_en;
            CSR_NSTAT: begin
                nice_csr_rdata[NSTAT_BUSY] = nice_busy;
                nice_csr_rdata[NSTAT_DONE] = done_f;
                nice_csr_rdata[NSTAT_ERR]  = err_f;
            end
            CSR_NARG0: nice_csr_rdata = narg0;
            CSR_NARG1: nice_csr_rdata = narg1;
            CSR_NRES:  nice_csr_rdata = nres;
            CSR_NCYC:  nice_csr_rdata = ncyc;
            default:   nice_csr_rdata = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)    state_next = ST_BUSY;
            ST_BUSY: if (mul_done) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    e203_nice_seqmul u_seqmul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (narg0),
        .b      (narg1),
        .done   (mul_done),
        .result (mul_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            irq_en <= 1'b0;
            done_f <= 1'b0;
            err_f  <= 1'b0;
            narg0  <= '0;
            narg1  <= '0;
            nres   <= '0;
            ncyc   <= '0;
        end else begin
            state <= state_next;
            if (state == ST_BUSY) begin
                ncyc <= ncyc + 32'd1;
            end
            if (mul_done) begin
                nres <= mul_res;
            end
            if (wr_acc && (idx == CSR_NCTRL)) begin
                irq_en <= nice_csr_wdata[NCTRL_IRQ_EN];
            end
            if (wr_acc && (idx == CSR_NARG0)) begin
                narg0 <= nice_csr_wdata;
            end
            if (wr_acc && (idx == CSR_NARG1)) begin
                narg1 <= nice_csr_wdata;
            end
            // Completion set beats a same-cycle W1C.
            if (mul_done) begin
                done_f <= 1'b1;
            end else if (wr_acc && (idx == CSR_NSTAT)
                         && nice_csr_wdata[NSTAT_DONE]) begin
                done_f <= 1'b0;
            end
            if (accept && !mapped) begin
                err_f <= 1'b1;
            end else if (wr_acc && (idx == CSR_NSTAT)
                         && nice_csr_wdata[NSTAT_ERR]) begin
                err_f <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_e203_nice_csr_resp.sv
// Self-checking bench for e203_nice_csr_resp.
// Scoreboard of expected read data, one task per scenario.
module tb_e203_nice_csr_resp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    wire         ready;
    wire         irq;
    wire         busy;
    wire  [31:0] rdata;

    int vectors = 0;
    int errs = 0;
    logic [31:0] m_ncyc = '0;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    e203_nice_csr_resp dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .nice_csr_valid (valid),
        .nice_csr_ready (ready),
        .nice_csr_addr  (addr),
        .nice_csr_wr    (wr),
        .nice_csr_wdata (wdata),
        .nice_csr_rdata (rdata),
        .nice_irq       (irq),
        .nice_busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic xfer(input logic [31:0] a, input logic w,
                        input logic [31:0] d,
                        output logic [31:0] rd, output int waits);
        @(negedge clk);
        valid = 1'b1;
        addr  = a;
        wr    = w;
        wdata = d;
        waits = 0;
        #1;
        while (!ready && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!ready) begin
            vectors++;
            errs++;
            $display("FAIL xfer_timeout %h: got ready=0 want ready=1", a);
            valid = 1'b0;
            rd = 'x;
            return;
        end
        rd = rdata;
        @(posedge clk);
        #1;
        valid = 1'b0;
        wr    = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ctrl, output int n);
        logic [31:0] rd;
        int w;
        xfer(32'hE02, 1'b1, a, rd, w);
        xfer(32'hE03, 1'b1, b, rd, w);
        xfer(32'hE00, 1'b1, ctrl, rd, w);
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        m_ncyc += 32;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] rd;
        int w;
        vectors++;
        if (ready !== 1'b1) begin
            errs++;
            $display("FAIL rst_ready: got %b want 1", ready);
        end
        vectors++;
        if (irq !== 1'b0) begin
            errs++;
            $display("FAIL rst_irq: got %b want 0", irq);
        end
        vectors++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL rst_busy: got %b want 0", busy);
        end
        sb.push_back('{"rst_nctrl", 32'hE00, 32'h0});
        sb.push_back('{"rst_nstat", 32'hE01, 32'h0});
        sb.push_back('{"rst_narg0", 32'hE02, 32'h0});
        sb.push_back('{"rst_narg1", 32'hE03, 32'h0});
        sb.push_back('{"rst_nres", 32'hE04, 32'h0});
        sb.push_back('{"rst_ncyc", 32'hE05, 32'h0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            xfer(e.addr, 1'b0, 32'h0, rd, w);
            vectors++;
            if (rd !== e.exp) begin
                errs++;
                $display("FAIL %s: got %h want %h", e.name, rd, e.exp);
            end
        end
    endtask

    task automatic test_mul_basic();
        exp_t e;
        logic [31:0] rd;
        int w, n;
        run_op(32'd3, 32'd5, 32'h1, n);
        vectors++;
        if (n !== 32) begin
            errs++;
            $display("FAIL busy_len: got %0d want 32", n);
        end
        vectors++;
        if (irq !== 1'b0) begin
            errs++;
            $display("FAIL irq_off: got %b want 0", irq);
        end
        sb.push_back('{"mul_nres", 32'hE04, 32'h0000000F});
        sb.push_back('{"mul_nstat", 32'hE01, 32'h2});
        sb.push_back('{"mul_ncyc", 32'hE05, m_ncyc});
        sb.push_back('{"mul_nctrl", 32'hE00, 32'h0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            xfer(e.addr, 1'b0, 32'h0, rd, w);
            vectors++;
            if (rd !== e.exp) begin
                errs++;
                $display("FAIL %s: got %h want %h", e.name, rd, e.exp);
            end
        end
    endtask

    task automatic test_mul_patterns();
        exp_t e;
        logic [31:0] rd, a, b, p;
        int w, n;
        logic [31:0] ta[4];
        logic [31:0] tb[4];
        ta[0] = 32'h00010000; tb[0] = 32'h00010000;
        ta[1] = 32'hFFFFFFFF; tb[1] = 32'hFFFFFFFF;
        ta[2] = $urandom;     tb[2] = $urandom;
        ta[3] = $urandom;     tb[3] = 32'h80000001;
        for (int i = 0; i < 4; i++) begin
            a = ta[i];
            b = tb[i];
            p = a * b;
            run_op(a, b, 32'h1, n);
            vectors++;
            if (n !== 32) begin
                errs++;
                $display("FAIL pat%0d_len: got %0d want 32", i, n);
            end
            sb.push_back('{"pat_nres", 32'hE04, p});
            while (sb.size() > 0) begin
                e = sb.pop_front();
                xfer(e.addr, 1'b0, 32'h0, rd, w);
                vectors++;
                if (rd !== e.exp) begin
                    errs++;
                    $display("FAIL %s%0d: got %h want %h (a=%h b=%h)",
                             e.name, i, rd, e.exp, a, b);
                end
            end
        end
        sb.push_back('{"pat_ncyc", 32'hE05, m_ncyc});
        e = sb.pop_front();
        xfer(e.addr, 1'b0, 32'h0, rd, w);
        vectors++;
        if (rd !== e.exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", e.name, rd, e.exp);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        logic [31:0] rd;
        int w;
        xfer(32'hE01, 1'b1, 32'h2, rd, w);
        xfer(32'hE02, 1'b1, 32'h12345678, rd, w);
        xfer(32'hE03, 1'b1, 32'h2, rd, w);
        xfer(32'hE00, 1'b1, 32'h1, rd, w);
        m_ncyc += 32;
        sb.push_back('{"busy_nstat", 32'hE01, 32'h1});
        e = sb.pop_front();
        xfer(e.addr, 1'b0, 32'h0, rd, w);
        vectors++;
        if (rd !== e.exp || w !== 0) begin
            errs++;
            $display("FAIL %s: got %h waits %0d want %h waits 0",
                     e.name, rd, w, e.exp);
        end
        sb.push_back('{"stall_narg0", 32'hE02, 32'h12345678});
        e = sb.pop_front();
        xfer(e.addr, 1'b0, 32'h0, rd, w);
        vectors++;
        if (rd !== e.exp || w !== 31) begin
            errs++;
            $display("FAIL %s: got %h waits %0d want %h waits 31",
                     e.name, rd, w, e.exp);
        end
        vectors++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL stall_idle: got %b want 0", busy);
        end
        sb.push_back('{"stall_nres", 32'hE04, 32'h2468ACF0});
        e = sb.pop_front();
        xfer(e.addr, 1'b0, 32'h0, rd, w);
        vectors++;
        if (rd !== e.exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", e.name, rd, e.exp);
        end
    endtask

    task automatic test_irq();
        exp_t e;
        logic [31:0] rd;
        int w, n;
        run_op(32'd7, 32'd6, 32'h3, n);
        vectors++;
        if (irq !== 1'b1) begin
            errs++;
            $display("FAIL irq_set: got %b want 1", irq);
        end
        sb.push_back('{"irq_nctrl", 32'hE00, 32'h2});
        sb.push_back('{"irq_nres", 32'hE04, 32'd42});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            xfer(e.addr, 1'b0, 32'h0, rd, w);
            vectors++;
            if (rd !== e.exp) begin
                errs++;
                $display("FAIL %s: got %h want %h", e.name, rd, e.exp);
            end
        end
        xfer(32'hE01, 1'b1, 32'h2, rd, w);
        vectors++;
        if (irq !== 1'b0) begin
            errs++;
            $display("FAIL irq_clr: got %b want 0", irq);
        end
        xfer(32'hE00, 1'b1, 32'h3, rd, w);
        m_ncyc += 32;
        repeat (31) @(posedge clk);
        xfer(32'hE01, 1'b1, 32'h2, rd, w);
        vectors++;
        if (busy !== 1'b0 || irq !== 1'b1) begin
            errs++;
            $display("FAIL w1c_race: got busy=%b irq=%b want busy=0 irq=1",
                     busy, irq);
        end
        sb.push_back('{"race_nstat", 32'hE01, 32'h2});
        e = sb.pop_front();
        xfer(e.addr, 1'b0, 32'h0, rd, w);
        vectors++;
        if (rd !== e.exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", e.name, rd, e.exp);
        end
    endtask

    task automatic test_unmapped();
        exp_t e;
        logic [31:0] rd;
        int w;
        sb.push_back('{"unmap_e3f", 32'h00000E3F, 32'h0});
        sb.push_back('{"unmap_100", 32'h00000100, 32'h0});
        sb.push_back('{"err_nstat", 32'h00000E01, 32'h6});
        sb.push_back('{"hi_bits", 32'hABCDEE02, 32'd7});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            xfer(e.addr, 1'b0, 32'h0, rd, w);
            vectors++;
            if (rd !== e.exp || w !== 0) begin
                errs++;
                $display("FAIL %s: got %h waits %0d want %h waits 0",
                         e.name, rd, w, e.exp);
            end
        end
        xfer(32'hE01, 1'b1, 32'h4, rd, w);
        xfer(32'hE04, 1'b1, 32'hDEAD, rd, w);
        xfer(32'hE05, 1'b1, 32'h0, rd, w);
        xfer(32'hE01, 1'b1, 32'h1, rd, w);
        sb.push_back('{"err_clr", 32'hE01, 32'h2});
        sb.push_back('{"ro_nres", 32'hE04, 32'd42});
        sb.push_back('{"ro_ncyc", 32'hE05, m_ncyc});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            xfer(e.addr, 1'b0, 32'h0, rd, w);
            vectors++;
            if (rd !== e.exp) begin
                errs++;
                $display("FAIL %s: got %h want %h", e.name, rd, e.exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [31:0] rd;
        int w;
        xfer(32'hE02, 1'b1, 32'd9, rd, w);
        xfer(32'hE03, 1'b1, 32'd9, rd, w);
        xfer(32'hE00, 1'b1, 32'h3, rd, w);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || ready !== 1'b1 || irq !== 1'b0) begin
            errs++;
            $display("FAIL mid_rst: got busy=%b ready=%b irq=%b want 0 1 0",
                     busy, ready, irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_ncyc = '0;
        sb.push_back('{"mid_nres", 32'hE04, 32'h0});
        sb.push_back('{"mid_ncyc", 32'hE05, m_ncyc});
        sb.push_back('{"mid_nstat", 32'hE01, 32'h0});
        sb.push_back('{"mid_narg0", 32'hE02, 32'h0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            xfer(e.addr, 1'b0, 32'h0, rd, w);
            vectors++;
            if (rd !== e.exp) begin
                errs++;
                $display("FAIL %s: got %h want %h", e.name, rd, e.exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        #23;
        test_reset();
        rst_n = 1'b1;
        test_reset();
        test_mul_basic();
        test_mul_patterns();
        test_stall();
        test_irq();
        test_unmapped();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
